// File: rtl/branch_predictor_pkg.sv
// ---------------------------------------------------------------------------
// bpred_pkg
// Shared types for the dynamic branch predictor.
//   ctr_t        : 2-bit saturating direction counter encoding
//   btb_entry_t  : one BTB slot {valid, tag, target}
//   sat_update() : saturating counter step toward the resolved outcome
// Default geometry is held here; the predictor's parameters default to these
// values so the entry struct and the datapath widths agree.
// ---------------------------------------------------------------------------
package bpred_pkg;

  localparam int BP_XLEN    = 32;
  localparam int BP_ENTRIES = 16;
  localparam int BP_TAG_W   = 8;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } ctr_t;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
  } btb_entry_t;

  // Move one step toward the observed direction; both ends hold.
  function automatic ctr_t sat_update(ctr_t c, logic taken);
    if (taken) begin
      return (c == STRONG_T) ? STRONG_T : ctr_t'(c + 2'd1);
    end
    return (c == STRONG_NT) ? STRONG_NT : ctr_t'(c - 2'd1);
  endfunction

endpackage

// File: rtl/branch_predictor_if.sv
// ---------------------------------------------------------------------------
// branch_predictor_if
// Bundles the fetch lookup, execute resolution, flush and statistics signals
// exchanged between the core (master) and the predictor (slave).
//   f_pc / f_pred_taken / f_pred_pc                 : fetch-stage lookup
//   e_valid, e_pc, e_taken, e_target,
//   e_pred_taken, e_pred_pc                          : resolved transfer
//   flush                                            : FENCE.I invalidate
//   mispredict / redirect_pc                         : redirect to the core
//   stat_branches / stat_mispredicts                 : performance counters
// ---------------------------------------------------------------------------
interface branch_predictor_if #(
  parameter int XLEN = 32
);
  logic [XLEN-1:0] f_pc;
  logic            f_pred_taken;
  logic [XLEN-1:0] f_pred_pc;
  logic            e_valid;
  logic [XLEN-1:0] e_pc;
  logic            e_taken;
  logic [XLEN-1:0] e_target;
  logic            e_pred_taken;
  logic [XLEN-1:0] e_pred_pc;
  logic            flush;
  logic            mispredict;
  logic [XLEN-1:0] redirect_pc;
  logic [31:0]     stat_branches;
  logic [31:0]     stat_mispredicts;

  modport master (
    output f_pc, e_valid, e_pc, e_taken, e_target, e_pred_taken, e_pred_pc, flush,
    input  f_pred_taken, f_pred_pc, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );

  modport slave (
    input  f_pc, e_valid, e_pc, e_taken, e_target, e_pred_taken, e_pred_pc, flush,
    output f_pred_taken, f_pred_pc, mispredict, redirect_pc,
           stat_branches, stat_mispredicts
  );
endinterface

// File: rtl/branch_predictor_table.sv
// ---------------------------------------------------------------------------
// bpred_table
// BTB entry and direction-counter storage.
//   clock, reset_n : clock, asynchronous active-low reset
//   flush_i        : invalidate every entry, counters back to WEAK_NT
//   rd_idx_i       : combinational read port -> rd_entry_o, rd_ctr_o
//   wr_en_i, wr_idx_i, wr_tag_i, wr_taken_i, wr_target_i
//                  : training port; hit/allocate decision is made here
// Registers (not RAM) because reset must clear targets asynchronously.
// ---------------------------------------------------------------------------
module bpred_table
  import bpred_pkg::*;
#(
  parameter int ENTRIES = BP_ENTRIES,
  parameter int IDX_W   = $clog2(ENTRIES)
) (
  input  logic                clock,
  input  logic                reset_n,
  input  logic                flush_i,
  input  logic [IDX_W-1:0]    rd_idx_i,
  output btb_entry_t          rd_entry_o,
  output ctr_t                rd_ctr_o,
  input  logic                wr_en_i,
  input  logic [IDX_W-1:0]    wr_idx_i,
  input  logic [BP_TAG_W-1:0] wr_tag_i,
  input  logic                wr_taken_i,
  input  logic [BP_XLEN-1:0]  wr_target_i
);

  btb_entry_t entry_q [ENTRIES];
  btb_entry_t entry_d [ENTRIES];
  ctr_t       ctr_q   [ENTRIES];
  ctr_t       ctr_d   [ENTRIES];
  logic       wr_hit;

  // Read reflects registered state only: a same-cycle write is not bypassed.
  assign rd_entry_o = entry_q[rd_idx_i];
  assign rd_ctr_o   = ctr_q[rd_idx_i];

  assign wr_hit = entry_q[wr_idx_i].valid && (entry_q[wr_idx_i].tag == wr_tag_i);

  always_comb begin
    entry_d = entry_q;
    ctr_d   = ctr_q;
    if (flush_i) begin
      // Flush takes priority over any training in the same cycle.
      for (int i = 0; i < ENTRIES; i++) begin
        entry_d[i].valid = 1'b0;
        ctr_d[i]         = WEAK_NT;
      end
    end else if (wr_en_i) begin
      if (wr_hit) begin
        ctr_d[wr_idx_i] = sat_update(ctr_q[wr_idx_i], wr_taken_i);
        if (wr_taken_i) begin
          entry_d[wr_idx_i].target = wr_target_i;
        end
      end else if (wr_taken_i) begin
        // Allocation evicts whatever alias occupied the slot.
        entry_d[wr_idx_i] = '{valid: 1'b1, tag: wr_tag_i, target: wr_target_i};
        ctr_d[wr_idx_i]   = WEAK_T;
      end
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        entry_q[i] <= '0;
        ctr_q[i]   <= WEAK_NT;
      end
    end else begin
      entry_q <= entry_d;
      ctr_q   <= ctr_d;
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// ---------------------------------------------------------------------------
// branch_predictor
// Direct-mapped BTB with 2-bit counters for the RV32I fetch stage.
//   clock, reset_n : clock, asynchronous active-low reset
//   bp (slave)     : fetch lookup, execute resolution/training, flush,
//                    mispredict/redirect and statistics outputs
// Optional feature macro: BPRED_STATS_EN enables the two 32-bit wrapping
// statistics counters; when undefined both stat outputs are tied to zero.
// ---------------------------------------------------------------------------
module branch_predictor
  import bpred_pkg::*;
#(
  parameter int XLEN    = BP_XLEN,
  parameter int ENTRIES = BP_ENTRIES,
  parameter int TAG_W   = BP_TAG_W
) (
  input  logic               clock,
  input  logic               reset_n,
  branch_predictor_if.slave  bp
);

  localparam int IDX_W = $clog2(ENTRIES);

  logic [IDX_W-1:0] f_idx, e_idx;
  logic [TAG_W-1:0] f_tag, e_tag;
  btb_entry_t       rd_entry;
  ctr_t             rd_ctr;
  logic             f_hit, f_taken;
  logic [XLEN-1:0]  correct_pc;
  logic             mispredict;
  logic             unused_ok;

  assign f_idx = bp.f_pc[IDX_W+1:2];
  assign f_tag = bp.f_pc[IDX_W+2 +: TAG_W];
  assign e_idx = bp.e_pc[IDX_W+1:2];
  assign e_tag = bp.e_pc[IDX_W+2 +: TAG_W];

  bpred_table #(
    .ENTRIES (ENTRIES),
    .IDX_W   (IDX_W)
  ) u_table (
    .clock       (clock),
    .reset_n     (reset_n),
    .flush_i     (bp.flush),
    .rd_idx_i    (f_idx),
    .rd_entry_o  (rd_entry),
    .rd_ctr_o    (rd_ctr),
    .wr_en_i     (bp.e_valid),
    .wr_idx_i    (e_idx),
    .wr_tag_i    (e_tag),
    .wr_taken_i  (bp.e_taken),
    .wr_target_i (bp.e_target)
  );

  // Fetch lookup
  assign f_hit           = rd_entry.valid && (rd_entry.tag == f_tag);
  assign f_taken         = f_hit && rd_ctr[1];
  assign bp.f_pred_taken = f_taken;
  assign bp.f_pred_pc    = f_taken ? rd_entry.target : bp.f_pc + XLEN'(4);

  // Execute resolution: only the predicted PC matters, so a taken branch
  // whose target equals pc+4 never redirects.
  assign correct_pc     = bp.e_taken ? bp.e_target : bp.e_pc + XLEN'(4);
  assign mispredict     = bp.e_valid && (bp.e_pred_pc != correct_pc);
  assign bp.mispredict  = mispredict;
  assign bp.redirect_pc = bp.e_valid ? correct_pc : '0;

  // Direction hint travels with the instruction but the PC comparison alone
  // decides a redirect; low PC bits and bits above the tag are not indexed.
  assign unused_ok = ^{bp.e_pred_taken, bp.f_pc, bp.e_pc};

`ifdef BPRED_STATS_EN
  logic [31:0] stat_br_q, stat_br_d;
  logic [31:0] stat_mis_q, stat_mis_d;

  always_comb begin
    stat_br_d  = stat_br_q + (bp.e_valid ? 32'd1 : 32'd0);
    stat_mis_d = stat_mis_q + (mispredict ? 32'd1 : 32'd0);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stat_br_q  <= '0;
      stat_mis_q <= '0;
    end else begin
      stat_br_q  <= stat_br_d;
      stat_mis_q <= stat_mis_d;
    end
  end

  assign bp.stat_branches    = stat_br_q;
  assign bp.stat_mispredicts = stat_mis_q;
`else
  assign bp.stat_branches    = '0;
  assign bp.stat_mispredicts = '0;
`endif

endmodule
